// File: rtl/equiv_miter_pkg.sv
// ---------------------------------------------------------------------------
// equiv_miter_pkg
// Shared definitions for the equivalence miter monitor:
//   - state_e   : monitor state encoding (IDLE/WARM/CHECK/HALT)
//   - MAX_SKEW  : largest supported alignment skew
//   - sat_inc() : saturating increment for the monitor counters (<= 32 bits)
// ---------------------------------------------------------------------------
package equiv_miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int unsigned MAX_SKEW = 15;

  // Returns v + 1, but never passes max_v; the caller supplies its
  // all-ones value so the same helper serves any counter width up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/equiv_skew_line.sv
// ---------------------------------------------------------------------------
// equiv_skew_line
// Valid-tagged delay chain used to align the early side of the miter.
// SKEW = 0 gives a combinational pass-through that is always valid.
// For SKEW > 0, data shifts only on enabled cycles; q_vld rises once
// SKEW enabled cycles have filled the chain, and flush marks every stage
// invalid again (flush has priority over en).
//
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   en     in  1  shift enable
//   flush  in  1  synchronous invalidate of all stages
//   d      in  W  input data
//   q      out W  data delayed SKEW enabled cycles
//   q_vld  out 1  every stage on the path holds real data
// ---------------------------------------------------------------------------
module equiv_skew_line #(
  parameter int unsigned W    = 8,
  parameter int unsigned SKEW = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         q_vld
);

  if (SKEW == 0) begin : g_pass
    assign q     = d;
    assign q_vld = 1'b1;

    // Clock/control are not needed without a chain.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en, flush};
  end else begin : g_chain
    logic [W-1:0]    data [SKEW];
    logic [SKEW-1:0] vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the data stages are reset along with the valid bits so the
        // aligned output reads 0, never X, straight out of reset.
        for (int i = 0; i < int'(SKEW); i++) data[i] <= '0;
        vld <= '0;
      end else if (flush) begin
        // Data may stay stale; only the tags need clearing.
        vld <= '0;
      end else if (en) begin
        data[0] <= d;
        vld[0]  <= 1'b1;
        for (int i = 1; i < int'(SKEW); i++) begin
          data[i] <= data[i-1];
          vld[i]  <= vld[i-1];
        end
      end
    end

    assign q     = data[SKEW-1];
    assign q_vld = &vld;
  end

endmodule

// File: rtl/equiv_miter_monitor.sv
// ---------------------------------------------------------------------------
// equiv_miter_monitor
// Cycle-by-cycle equivalence miter between two DUT output buses with skew
// alignment, post-enable warm-up, don't-care mask, saturating counters,
// first-mismatch capture and optional stop-on-first-fail.
//
// Parameters:
//   W            compared bus width
//   SKEW         cycles y_a is delayed before compare (0..MAX_SKEW)
//   WARMUP       enabled cycles ignored after leaving IDLE
//   CNT_W        width of mis_cnt / cyc_cnt / first_cyc (<= 32)
//   STOP_ON_FAIL 1 = go to HALT and freeze on the first mismatch
//
// Ports:
//   clk, rst_n         clock / async active-low reset
//   en                 compare enable (state and counters hold while low)
//   y_a, y_b           DUT A / DUT B outputs
//   mask               1 = bit compared, 0 = don't care
//   clr                synchronous clear of sticky, capture and counters
//   state              0 IDLE, 1 WARM, 2 CHECK, 3 HALT
//   mismatch           registered pulse, compare failed on the previous edge
//   fail               sticky first-fail flag
//   mis_cnt, cyc_cnt   saturating mismatch / compare-cycle counters
//   first_cyc          cyc_cnt value (pre-increment) at the first mismatch
//   first_a, first_b   aligned y_a and y_b at the first mismatch
//
// Build option: define EQUIV_MITER_ASSERT_EN to add an immediate
// assert(!diff) on every CHECK compare, for formal flows. Ports are the
// same either way.
// ---------------------------------------------------------------------------
module equiv_miter_monitor
  import equiv_miter_pkg::*;
#(
  parameter int unsigned W            = 91,
  parameter int unsigned SKEW         = 0,
  parameter int unsigned WARMUP       = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     y_a,
  input  logic [W-1:0]     y_b,
  input  logic [W-1:0]     mask,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] first_cyc,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b
);

  localparam int unsigned     WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]   WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e        st;
  logic [WW-1:0] warm_cnt;
  logic [W-1:0]  a_al;
  logic          a_vld;
  logic          diff;

  equiv_skew_line #(
    .W    (W),
    .SKEW (SKEW)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .flush (clr),
    .d     (y_a),
    .q     (a_al),
    .q_vld (a_vld)
  );

  assign diff  = |((a_al ^ y_b) & mask);
  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every sequential assignment is non-blocking so all registers
      // update from the same pre-edge values (first_cyc relies on this to
      // see cyc_cnt before its increment).
      st        <= ST_IDLE;
      warm_cnt  <= '0;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      mis_cnt   <= '0;
      cyc_cnt   <= '0;
      first_cyc <= '0;
      first_a   <= '0;
      first_b   <= '0;
    end else if (clr) begin
      // Clear beats a coincident diff: nothing is counted or captured.
      st        <= ST_IDLE;
      warm_cnt  <= '0;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      mis_cnt   <= '0;
      cyc_cnt   <= '0;
      first_cyc <= '0;
      first_a   <= '0;
      first_b   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (en) begin
        unique case (st)
          ST_IDLE: begin
            warm_cnt <= '0;
            st       <= (WARMUP == 0) ? ST_CHECK : ST_WARM;
          end
          ST_WARM: begin
            if (warm_cnt == WARM_LAST) st <= ST_CHECK;
            else                       warm_cnt <= warm_cnt + 1'b1;
          end
          ST_CHECK: begin
            // Nothing is compared until the alignment chain has filled.
            if (a_vld) begin
`ifdef EQUIV_MITER_ASSERT_EN
              assert (!diff);
`endif
              cyc_cnt <= CNT_W'(sat_inc(32'(cyc_cnt), 32'(CNT_MAX)));
              if (diff) begin
                mismatch <= 1'b1;
                mis_cnt  <= CNT_W'(sat_inc(32'(mis_cnt), 32'(CNT_MAX)));
                if (!fail) begin
                  fail      <= 1'b1;
                  first_cyc <= cyc_cnt;
                  first_a   <= a_al;
                  first_b   <= y_b;
                end
                if (STOP_ON_FAIL != 0) st <= ST_HALT;
              end
            end
          end
          ST_HALT: begin
            // Frozen until clr or reset.
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// ---------------------------------------------------------------------------
// tb_equiv_miter_monitor
// Directed bench for equiv_miter_monitor. Five W=8, WARMUP=2 instances share
// one set of inputs; each phase starts from reset or clr so only the
// instance under test matters:
//   u_s0  SKEW=0 STOP_ON_FAIL=1
//   u_c   SKEW=0 STOP_ON_FAIL=0
//   u_k3  SKEW=3 STOP_ON_FAIL=1
//   u_k2  SKEW=2 STOP_ON_FAIL=1
//   u_sat SKEW=0 STOP_ON_FAIL=0 CNT_W=4
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_equiv_miter_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] y_a;
  logic [7:0] y_b;
  logic [7:0] mask;

  int checks = 0;
  int errors = 0;

  logic [1:0]  st_s0, st_c, st_k3, st_k2, st_sat;
  logic        mm_s0, mm_c, mm_k3, mm_k2, mm_sat;
  logic        fl_s0, fl_c, fl_k3, fl_k2, fl_sat;
  logic [15:0] mc_s0, mc_c, mc_k3, mc_k2;
  logic [15:0] cc_s0, cc_c, cc_k3, cc_k2;
  logic [15:0] fc_s0, fc_c, fc_k3, fc_k2;
  logic [3:0]  mc_sat, cc_sat, fc_sat;
  logic [7:0]  fa_s0, fa_c, fa_k3, fa_k2, fa_sat;
  logic [7:0]  fb_s0, fb_c, fb_k3, fb_k2, fb_sat;

  // Skew-phase history of y_a (h0 = previous edge) and next random value.
  logic [7:0] h0, h1, h2, v;

  equiv_miter_monitor #(.W(8), .SKEW(0), .WARMUP(2), .CNT_W(16), .STOP_ON_FAIL(1)) u_s0 (
    .clk(clk), .rst_n(rst_n), .en(en), .y_a(y_a), .y_b(y_b), .mask(mask), .clr(clr),
    .state(st_s0), .mismatch(mm_s0), .fail(fl_s0), .mis_cnt(mc_s0), .cyc_cnt(cc_s0),
    .first_cyc(fc_s0), .first_a(fa_s0), .first_b(fb_s0));

  equiv_miter_monitor #(.W(8), .SKEW(0), .WARMUP(2), .CNT_W(16), .STOP_ON_FAIL(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .y_a(y_a), .y_b(y_b), .mask(mask), .clr(clr),
    .state(st_c), .mismatch(mm_c), .fail(fl_c), .mis_cnt(mc_c), .cyc_cnt(cc_c),
    .first_cyc(fc_c), .first_a(fa_c), .first_b(fb_c));

  equiv_miter_monitor #(.W(8), .SKEW(3), .WARMUP(2), .CNT_W(16), .STOP_ON_FAIL(1)) u_k3 (
    .clk(clk), .rst_n(rst_n), .en(en), .y_a(y_a), .y_b(y_b), .mask(mask), .clr(clr),
    .state(st_k3), .mismatch(mm_k3), .fail(fl_k3), .mis_cnt(mc_k3), .cyc_cnt(cc_k3),
    .first_cyc(fc_k3), .first_a(fa_k3), .first_b(fb_k3));

  equiv_miter_monitor #(.W(8), .SKEW(2), .WARMUP(2), .CNT_W(16), .STOP_ON_FAIL(1)) u_k2 (
    .clk(clk), .rst_n(rst_n), .en(en), .y_a(y_a), .y_b(y_b), .mask(mask), .clr(clr),
    .state(st_k2), .mismatch(mm_k2), .fail(fl_k2), .mis_cnt(mc_k2), .cyc_cnt(cc_k2),
    .first_cyc(fc_k2), .first_a(fa_k2), .first_b(fb_k2));

  equiv_miter_monitor #(.W(8), .SKEW(0), .WARMUP(2), .CNT_W(4), .STOP_ON_FAIL(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .y_a(y_a), .y_b(y_b), .mask(mask), .clr(clr),
    .state(st_sat), .mismatch(mm_sat), .fail(fl_sat), .mis_cnt(mc_sat), .cyc_cnt(cc_sat),
    .first_cyc(fc_sat), .first_a(fa_sat), .first_b(fb_sat));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, returning 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    y_a   = 8'h00;
    y_b   = 8'h00;
    mask  = 8'hFF;
    h0 = 8'h00; h1 = 8'h00; h2 = 8'h00; v = 8'h00;

    // ---- reset state ----
    #3 rst_n = 1'b0;
    #9;
    check("rst_state",     32'(st_s0), 32'd0);
    check("rst_mismatch",  32'(mm_s0), 32'd0);
    check("rst_fail",      32'(fl_s0), 32'd0);
    check("rst_mis_cnt",   32'(mc_s0), 32'd0);
    check("rst_cyc_cnt",   32'(cc_s0), 32'd0);
    check("rst_first_cyc", 32'(fc_s0), 32'd0);
    check("rst_first_a",   32'(fa_s0), 32'd0);
    check("rst_first_b",   32'(fb_s0), 32'd0);
    rst_n = 1'b1;

    // ---- 20 equal enabled cycles: WARM after edge 1, CHECK after edge 3 ----
    en  = 1'b1;
    y_a = 8'h5A;
    y_b = 8'h5A;
    step(1);
    check("eq_state_e1", 32'(st_s0), 32'd1);
    step(2);
    check("eq_state_e3", 32'(st_s0), 32'd2);
    check("eq_cyc_e3",   32'(cc_s0), 32'd0);
    step(17);
    check("eq_cyc_e20",  32'(cc_s0), 32'd17);
    check("eq_mis_e20",  32'(mc_s0), 32'd0);
    check("eq_fail_e20", 32'(fl_s0), 32'd0);
    check("eq_state_e20",32'(st_s0), 32'd2);

    // ---- en=0 holds everything even with differing data ----
    en  = 1'b0;
    y_b = 8'h00;
    step(3);
    check("hold_cyc",      32'(cc_s0), 32'd17);
    check("hold_mismatch", 32'(mm_s0), 32'd0);
    check("hold_fail",     32'(fl_s0), 32'd0);
    check("hold_state",    32'(st_s0), 32'd2);

    // ---- clr coincident with a diff: clr wins ----
    en  = 1'b1;
    clr = 1'b1;
    step(1);
    check("clr_state",    32'(st_s0), 32'd0);
    check("clr_fail",     32'(fl_s0), 32'd0);
    check("clr_mismatch", 32'(mm_s0), 32'd0);
    check("clr_cyc",      32'(cc_s0), 32'd0);
    check("clr_first_b",  32'(fb_s0), 32'd0);
    clr = 1'b0;

    // ---- first mismatch at CHECK cycle 4 (5th compare) ----
    y_b = 8'h5A;
    step(7);
    check("pre_fail_cyc", 32'(cc_s0), 32'd4);
    y_b = 8'h5B;
    step(1);
    check("stop_mismatch",  32'(mm_s0), 32'd1);
    check("stop_fail",      32'(fl_s0), 32'd1);
    check("stop_first_cyc", 32'(fc_s0), 32'd4);
    check("stop_first_a",   32'(fa_s0), 32'h5A);
    check("stop_first_b",   32'(fb_s0), 32'h5B);
    check("stop_state",     32'(st_s0), 32'd3);
    check("stop_mis_cnt",   32'(mc_s0), 32'd1);
    check("stop_cyc_cnt",   32'(cc_s0), 32'd5);
    check("cont_state_1",   32'(st_c),  32'd2);
    check("cont_fail_1",    32'(fl_c),  32'd1);

    y_b = 8'h5A;
    step(2);
    check("halt_mismatch", 32'(mm_s0), 32'd0);
    check("halt_cyc",      32'(cc_s0), 32'd5);
    check("halt_mis",      32'(mc_s0), 32'd1);
    check("halt_state",    32'(st_s0), 32'd3);
    check("cont_cyc_7",    32'(cc_c),  32'd7);

    // ---- STOP_ON_FAIL=0: two more separate differing cycles ----
    y_b = 8'h00;
    step(1);
    check("cont_mm_2",  32'(mm_c), 32'd1);
    check("cont_mis_2", 32'(mc_c), 32'd2);
    y_b = 8'h5A;
    step(1);
    check("cont_mm_gap", 32'(mm_c), 32'd0);
    y_b = 8'h5C;
    step(1);
    check("cont_mis_3",   32'(mc_c), 32'd3);
    check("cont_cyc_10",  32'(cc_c), 32'd10);
    check("cont_first_c", 32'(fc_c), 32'd4);
    check("cont_first_a", 32'(fa_c), 32'h5A);
    check("cont_first_b", 32'(fb_c), 32'h5B);
    check("cont_state_3", 32'(st_c), 32'd2);
    check("halt_mis_fz",  32'(mc_s0), 32'd1);

    // ---- mask behaviour ----
    y_b = 8'h5A;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(3);
    check("mask_state", 32'(st_s0), 32'd2);
    mask = 8'h00;
    y_a  = 8'h12;
    y_b  = 8'hED;
    step(1);
    check("mask0_mismatch", 32'(mm_s0), 32'd0);
    check("mask0_cyc",      32'(cc_s0), 32'd1);
    mask = 8'hF0;
    y_b  = 8'h1F;
    step(1);
    check("maskF0_low_diff", 32'(mm_s0), 32'd0);
    check("maskF0_cyc",      32'(cc_s0), 32'd2);
    y_b = 8'h22;
    step(1);
    check("maskF0_hi_diff", 32'(mm_s0), 32'd1);
    check("maskF0_fail",    32'(fl_s0), 32'd1);
    check("maskF0_first_c", 32'(fc_s0), 32'd2);
    check("maskF0_first_b", 32'(fb_s0), 32'h22);

    // ---- skew alignment: y_b is y_a delayed 3 enabled cycles ----
    mask = 8'hFF;
    clr  = 1'b1;
    step(1);
    clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      // Random value guaranteed to differ from the previous y_a.
      v = 8'($urandom_range(0, 254));
      if (v >= h0) v = v + 8'd1;
      y_b = h2;
      y_a = v;
      step(1);
      h2 = h1;
      h1 = h0;
      h0 = y_a;
    end
    check("skew3_fail",  32'(fl_k3), 32'd0);
    check("skew3_mis",   32'(mc_k3), 32'd0);
    check("skew3_cyc",   32'(cc_k3), 32'd97);
    check("skew3_state", 32'(st_k3), 32'd2);
    check("skew2_fail",  32'(fl_k2), 32'd1);
    check("skew2_first", 32'(fc_k2), 32'd0);
    check("skew2_state", 32'(st_k2), 32'd3);

    // ---- CNT_W=4 saturation with 20 mismatches ----
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    y_a = 8'hA5;
    y_b = 8'hA5;
    step(3);
    y_b = 8'h5A;
    step(20);
    check("sat_mis",      32'(mc_sat), 32'd15);
    check("sat_cyc",      32'(cc_sat), 32'd15);
    check("sat_fail",     32'(fl_sat), 32'd1);
    check("sat_first_c",  32'(fc_sat), 32'd0);
    check("sat_first_a",  32'(fa_sat), 32'hA5);
    check("sat_state",    32'(st_sat), 32'd2);
    check("sat_mismatch", 32'(mm_sat), 32'd1);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("satclr_state",    32'(st_sat), 32'd0);
    check("satclr_mismatch", 32'(mm_sat), 32'd0);
    check("satclr_fail",     32'(fl_sat), 32'd0);
    check("satclr_mis",      32'(mc_sat), 32'd0);
    check("satclr_cyc",      32'(cc_sat), 32'd0);
    check("satclr_first_c",  32'(fc_sat), 32'd0);
    check("satclr_first_a",  32'(fa_sat), 32'd0);
    check("satclr_first_b",  32'(fb_sat), 32'd0);

    // ---- asynchronous reset mid-CHECK ----
    step(5);
    check("prerst_state", 32'(st_sat), 32'd2);
    check("prerst_mis",   32'(mc_sat), 32'd2);
    check("prerst_fail",  32'(fl_sat), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state",   32'(st_sat), 32'd0);
    check("arst_mis",     32'(mc_sat), 32'd0);
    check("arst_cyc",     32'(cc_sat), 32'd0);
    check("arst_fail",    32'(fl_sat), 32'd0);
    check("arst_first_a", 32'(fa_sat), 32'd0);
    check("arst_state_c", 32'(st_c),   32'd0);
    #3 rst_n = 1'b1;
    step(1);
    check("rerst_warm", 32'(st_sat), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/equiv_miter_monitor.md
Name: equiv_miter_monitor

Overview:
- Parametrised successor to the per-cycle equivalence miter used in fuzz proofs. It compares two DUT output buses (y_a, y_b) of configurable width.
- Adds the following over a plain per-cycle compare:
  - Skew alignment between the two sides.
  - A post-reset warm-up window.
  - A don't-care bit mask.
  - A saturating mismatch counter.
  - First-mismatch capture.
  - A stop-on-first-fail mode.
- Sits in the proof/sim top between the two DUT instances and the formal/sim harness.

Parameters:
- W, 91, compared bus width (bits).
- SKEW, 0, cycles y_a is delayed before compare (0..15). Use it when variant A is that many cycles early.
- WARMUP, 2, cycles after the first enabled cycle during which compares are ignored.
- CNT_W, 16, width of the mismatch and cycle counters.
- STOP_ON_FAIL, 1, 1 = freeze all captures and counting after the first mismatch.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  compare enable; while low, the monitor holds its state and counters
- y_a  in  W  DUT A output
- y_b  in  W  DUT B output
- mask  in  W  1 = bit compared, 0 = don't care
- clr  in  1  synchronous clear of sticky/capture state (not counters' config)
- state  out  2  0 IDLE, 1 WARM, 2 CHECK, 3 HALT
- mismatch  out  1  registered pulse: compare failed this cycle
- fail  out  1  sticky; set on the first mismatch
- mis_cnt  out  CNT_W  mismatches counted, saturating
- cyc_cnt  out  CNT_W  enabled CHECK cycles, saturating
- first_cyc  out  CNT_W  value of cyc_cnt at the first mismatch
- first_a  out  W  aligned y_a at the first mismatch
- first_b  out  W  y_b at the first mismatch

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, delay line cleared, warm-up counter 0.
- Alignment:
  - a_al = y_a delayed SKEW cycles through a register chain; SKEW=0 means combinational pass-through.
  - Delay-line entries are marked valid only after SKEW enabled cycles.
  - No compare occurs while any entry in the path is invalid.
- Compare: diff = ((a_al ^ y_b) & mask) != 0.
- State machine, advancing only when en=1:
  - IDLE -> WARM on the first en.
  - WARM counts WARMUP cycles, then goes to CHECK. WARMUP=0 means IDLE -> CHECK directly.
  - CHECK compares every enabled, aligned-valid cycle.
  - On diff:
    - mismatch pulses 1 cycle later (registered, latency 1).
    - mis_cnt increments.
    - If fail=0: set fail and capture first_cyc/first_a/first_b.
    - If STOP_ON_FAIL=1, go to HALT.
  - HALT holds everything. mismatch stays 0 and counters freeze.
- Counters saturate at 2^CNT_W-1 and never wrap. cyc_cnt increments on each CHECK compare cycle, including the mismatching one. first_cyc records the pre-increment value.
- en=0 in any state: no state change and no count. The delay line holds, so no shift occurs.
- clr=1 (synchronous, highest priority after reset):
  - fail, captures, mis_cnt, cyc_cnt and mismatch go to 0.
  - State goes to IDLE.
  - The delay line is flushed to invalid.
- Simultaneous clr and diff: clr wins and nothing is captured.
- Reset mid-CHECK: immediate return to IDLE with everything cleared. Warm-up restarts.
- mask=0: never mismatches, but cyc_cnt still counts.

Optional Feature:
- EQUIV_MITER_ASSERT_EN: when defined, an immediate assert (!diff) is placed in the clocked block, active in CHECK only, for formal flows.
- Without the macro, no assertion is emitted; the failure is reported only through the fail/mismatch ports.
- Port list is identical in both cases.

Decomposition:
- Package equiv_miter_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_WARM=1, ST_CHECK=2, ST_HALT=3)
  - a saturating-increment function
  - MAX_SKEW=15
- Sub-module equiv_skew_line (W, SKEW) holds the valid-tagged delay chain with enable and flush.

Test Plan:
- W=8, SKEW=0, WARMUP=2, y_a=y_b=0x5A for 20 enabled cycles -> state reaches CHECK at cycle 3; fail=0, mis_cnt=0, cyc_cnt=17.
- Same setup, y_b=0x5B at CHECK cycle 4 -> mismatch pulse the next cycle; fail=1, first_cyc=4, first_a=0x5A, first_b=0x5B, state=HALT, counters frozen.
- STOP_ON_FAIL=0, three separate differing cycles -> mis_cnt=3; first_* captures the first difference only; state stays CHECK.
- SKEW=3, y_b = y_a delayed by 3 with random data -> no mismatch over 100 cycles. With SKEW=2 instead -> fail within 4 CHECK cycles.
- mask=0xF0, y_a=0x12, y_b=0x1F -> no mismatch. With y_b=0x22 -> mismatch.
- CNT_W=4, 20 mismatches with STOP_ON_FAIL=0 -> mis_cnt=15 (saturated). Assert clr -> all outputs 0, state IDLE. Drop rst_n mid-CHECK -> outputs 0 asynchronously.
